// File: rtl/lcd_pkg.sv
// Shared command set, DDRAM row bases and state encodings for the character-LCD controller.
package lcd_pkg;

  localparam logic [7:0] FUNC_8B_2L = 8'h38;
  localparam logic [7:0] FUNC_8B_1L = 8'h30;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY_INC  = 8'h06;
  localparam logic [7:0] SET_DDRAM  = 8'h80;

  localparam int INIT_LEN = 6;

  // Rows 2 and 3 continue rows 0 and 1 in DDRAM on 4-line glass.
  localparam logic [7:0] ROW_BASE [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, DATA} state_t;
  typedef enum logic [1:0] {T0, T1, T2, WAIT} phase_t;

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running divider: one-cycle tick every TICK_CYCLES clocks after reset release.
module lcd_tick_gen #(
  parameter int TICK_CYCLES = 2000
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == CW'(TICK_CYCLES - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(TICK_CYCLES - 1));

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780-class 8-bit write-only controller: power-up wait, init sequence, then
// whole-frame writes captured on a valid/ready handshake, paced by the tick strobe.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int ROWS          = 2,
  parameter int COLS          = 16,
  parameter int TICK_CYCLES   = 2000,
  parameter int POWERUP_TICKS = 500,
  parameter int CLEAR_TICKS   = 50,
  parameter int AUTO_REFRESH  = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ROWS*COLS*8-1:0] message_in,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  output logic                   busy,
  output logic                   lcd_en,
  output logic                   lcd_rs,
  output logic                   lcd_rw,
  output logic [7:0]             lcd_d
);

  localparam int NCH = ROWS * COLS;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = $clog2(COLS);
  localparam int IW  = $clog2(NCH);
  localparam int PW  = $clog2(POWERUP_TICKS + 1);
  localparam int WW  = $clog2(CLEAR_TICKS + 2);
  localparam bit HAS_CLR = (CLEAR_TICKS > 0);
  localparam bit AUTO    = (AUTO_REFRESH != 0);
  localparam logic [7:0] FUNC_CMD = (ROWS >= 2) ? FUNC_8B_2L : FUNC_8B_1L;

  state_t          state;
  phase_t          phase;
  logic [2:0]      init_idx;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [PW-1:0]   pwr_cnt;
  logic [WW-1:0]   wait_cnt;
  logic [NCH*8-1:0] frame;

  logic            tick;
  logic [IW-1:0]   char_idx;
  logic [7:0]      cur_byte;
  logic            cur_rs;
  logic            is_clear;
  logic            byte_done;
  logic            last_col;
  logic            last_row;
  logic            capture;

  lcd_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  assign lcd_rw = 1'b0;

  always_comb begin
    char_idx = IW'(row) * IW'(COLS) + IW'(col);
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    case (state)
      INIT: begin
        case (init_idx)
          3'd0, 3'd1, 3'd2: cur_byte = FUNC_CMD;
          3'd3:             cur_byte = DISP_ON;
          3'd4:             cur_byte = CLEAR;
          default:          cur_byte = ENTRY_INC;
        endcase
      end
      ADDR: cur_byte = SET_DDRAM | ROW_BASE[2'(row)];
      DATA: begin
        cur_byte = frame[{char_idx, 3'b000} +: 8];
        cur_rs   = 1'b1;
      end
      default: cur_byte = 8'h00;
    endcase
    is_clear  = (state == INIT) && (init_idx == 3'd4);
    last_col  = (col == CW'(COLS - 1));
    last_row  = (row == RW'(ROWS - 1));
    // A byte retires on its T2 tick, or on the last settle tick after a clear.
    byte_done = tick && (((phase == T2) && !(is_clear && HAS_CLR)) ||
                         ((phase == WAIT) && (wait_cnt == WW'(1))));
    capture   = (state == IDLE) && msg_ready && (msg_valid || AUTO);
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      frame <= message_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= PWRUP;
      phase     <= T0;
      init_idx  <= '0;
      row       <= '0;
      col       <= '0;
      pwr_cnt   <= '0;
      wait_cnt  <= '0;
      msg_ready <= 1'b0;
      busy      <= 1'b1;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_d     <= 8'h00;
    end else begin
      case (state)
        PWRUP: begin
          if (tick) begin
            if (pwr_cnt == PW'(POWERUP_TICKS - 1)) begin
              state    <= INIT;
              init_idx <= '0;
              phase    <= T0;
            end else begin
              pwr_cnt <= pwr_cnt + 1'b1;
            end
          end
        end
        IDLE: begin
          if (capture) begin
            msg_ready <= 1'b0;
            busy      <= 1'b1;
            row       <= '0;
            phase     <= T0;
            state     <= ADDR;
          end
        end
        default: begin
          if (tick) begin
            case (phase)
              T0: begin
                lcd_rs <= cur_rs;
                lcd_d  <= cur_byte;
                lcd_en <= 1'b0;
                phase  <= T1;
              end
              T1: begin
                lcd_en <= 1'b1;
                phase  <= T2;
              end
              T2: begin
                lcd_en   <= 1'b0;
                wait_cnt <= WW'(CLEAR_TICKS);
                phase    <= (is_clear && HAS_CLR) ? WAIT : T0;
              end
              WAIT: begin
                if (wait_cnt == WW'(1)) begin
                  phase <= T0;
                end else begin
                  wait_cnt <= wait_cnt - 1'b1;
                end
              end
            endcase
            if (byte_done) begin
              case (state)
                INIT: begin
                  if (init_idx == 3'(INIT_LEN - 1)) begin
                    state     <= IDLE;
                    msg_ready <= 1'b1;
                    busy      <= 1'b0;
                  end else begin
                    init_idx <= init_idx + 1'b1;
                  end
                end
                ADDR: begin
                  state <= DATA;
                  col   <= '0;
                end
                DATA: begin
                  if (last_col) begin
                    if (last_row) begin
                      state     <= IDLE;
                      msg_ready <= 1'b1;
                      busy      <= 1'b0;
                    end else begin
                      row   <= row + 1'b1;
                      state <= ADDR;
                    end
                  end else begin
                    col <= col + 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: three instances (2x16, 4x20, 2x16 auto-refresh) checked
// against a byte-sequence model built from the command set and frame layout.
module tb_lcd_text_ctrl;

  localparam int T   = 4;
  localparam int PWR = 5;
  localparam int CLR = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic         m_rst, m_valid, m_ready, m_busy, m_en, m_rs, m_rw;
  logic [7:0]   m_d;
  logic [255:0] m_msg;
  logic         w_rst, w_valid, w_ready, w_busy, w_en, w_rs, w_rw;
  logic [7:0]   w_d;
  logic [639:0] w_msg;
  logic         a_rst, a_valid, a_ready, a_busy, a_en, a_rs, a_rw;
  logic [7:0]   a_d;
  logic [255:0] a_msg;

  lcd_text_ctrl #(.ROWS(2), .COLS(16), .TICK_CYCLES(T), .POWERUP_TICKS(PWR),
                  .CLEAR_TICKS(CLR), .AUTO_REFRESH(0)) u_main (
    .clock(clock), .reset(m_rst), .message_in(m_msg), .msg_valid(m_valid),
    .msg_ready(m_ready), .busy(m_busy), .lcd_en(m_en), .lcd_rs(m_rs),
    .lcd_rw(m_rw), .lcd_d(m_d));

  lcd_text_ctrl #(.ROWS(4), .COLS(20), .TICK_CYCLES(T), .POWERUP_TICKS(PWR),
                  .CLEAR_TICKS(CLR), .AUTO_REFRESH(0)) u_wide (
    .clock(clock), .reset(w_rst), .message_in(w_msg), .msg_valid(w_valid),
    .msg_ready(w_ready), .busy(w_busy), .lcd_en(w_en), .lcd_rs(w_rs),
    .lcd_rw(w_rw), .lcd_d(w_d));

  lcd_text_ctrl #(.ROWS(2), .COLS(16), .TICK_CYCLES(T), .POWERUP_TICKS(PWR),
                  .CLEAR_TICKS(CLR), .AUTO_REFRESH(1)) u_auto (
    .clock(clock), .reset(a_rst), .message_in(a_msg), .msg_valid(a_valid),
    .msg_ready(a_ready), .busy(a_busy), .lcd_en(a_en), .lcd_rs(a_rs),
    .lcd_rw(a_rw), .lcd_d(a_d));

  // Each E rise is logged as {cycle, rs, d}.
  logic [40:0] mq[$], wq[$], aq[$], obs_q[$];
  logic [8:0]  exp_q[$];
  logic        m_en_q = 0, w_en_q = 0, a_en_q = 0;
  logic [31:0] m_t_rise = 0;
  logic [8:0]  m_hold = 0;
  int          bad_width = 0, unstable = 0, rw_bad = 0;

  always @(negedge clock) begin
    if (m_en && !m_en_q) begin
      mq.push_back({cyc, m_rs, m_d});
      m_t_rise = cyc;
      m_hold   = {m_rs, m_d};
    end
    if (!m_en && m_en_q && (cyc - m_t_rise) != 32'(T)) bad_width++;
    if (m_en && ({m_rs, m_d} !== m_hold)) unstable++;
    if (w_en && !w_en_q) wq.push_back({cyc, w_rs, w_d});
    if (a_en && !a_en_q) aq.push_back({cyc, a_rs, a_d});
    if ((m_rw | w_rw | a_rw) !== 1'b0) rw_bad++;
    m_en_q = m_en;
    w_en_q = w_en;
    a_en_q = a_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_init(input int rows);
    logic [7:0] f;
    f = (rows >= 2) ? 8'h38 : 8'h30;
    exp_q.push_back({1'b0, f});
    exp_q.push_back({1'b0, f});
    exp_q.push_back({1'b0, f});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic add_frame(input int rows, input int cols, input logic [639:0] fr);
    int base_tab[4] = '{0, 64, 20, 84};
    for (int r = 0; r < rows; r++) begin
      exp_q.push_back({1'b0, 8'h80 | 8'(base_tab[r])});
      for (int c = 0; c < cols; c++)
        exp_q.push_back({1'b1, fr[8*(r*cols+c) +: 8]});
    end
  endtask

  task automatic cmp_seq(input string tag);
    int n;
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s[%0d]", tag, i), {23'd0, obs_q[i][8:0]}, {23'd0, exp_q[i]});
  endtask

  // Init pacing: 3 ticks between E rises, plus the clear settle time after 0x01.
  task automatic check_init_gaps(input string tag);
    for (int i = 1; i < 6 && i < obs_q.size(); i++)
      check($sformatf("%s_gap%0d", tag, i), obs_q[i][40:9] - obs_q[i-1][40:9],
            32'(3*T + ((exp_q[i-1][7:0] == 8'h01) ? CLR*T : 0)));
  endtask

  function automatic logic ready_of(input int w);
    case (w)
      0:       return m_ready;
      1:       return w_ready;
      default: return a_ready;
    endcase
  endfunction

  task automatic wait_ready(input string tag, input int w, input int budget);
    int n = 0;
    while (ready_of(w) !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_ready_timeout"}, {31'd0, ready_of(w)}, 1);
  endtask

  function automatic logic [639:0] rand_frame();
    logic [639:0] f;
    for (int k = 0; k < 80; k++) f[8*k +: 8] = 8'($urandom_range(32, 126));
    return f;
  endfunction

  initial begin
    string        s;
    logic [639:0] hello, fa, fb, fc;
    logic [31:0]  rel;
    int           n, ready_leak;

    s = "HELLO WORLD     0123456789ABCDEF";
    hello = '0;
    for (int k = 0; k < 32; k++) hello[8*k +: 8] = s[k];
    fa = rand_frame();
    fb = rand_frame();
    fc = rand_frame();

    m_rst = 0; w_rst = 0; a_rst = 0;
    m_valid = 0; w_valid = 0; a_valid = 0;
    m_msg = '0; w_msg = '0; a_msg = '0;
    repeat (3) @(negedge clock);

    check("rst_en", {31'd0, m_en}, 0);
    check("rst_rs", {31'd0, m_rs}, 0);
    check("rst_rw", {31'd0, m_rw}, 0);
    check("rst_d", {24'd0, m_d}, 0);
    check("rst_ready", {31'd0, m_ready}, 0);
    check("rst_busy", {31'd0, m_busy}, 1);

    // Power-up and init sequence.
    m_rst = 1;
    rel = cyc;
    wait_ready("init", 0, 3000);
    obs_q = mq;
    exp_q.delete();
    add_init(2);
    cmp_seq("init");
    check_init_gaps("init");
    if (mq.size() > 0) begin
      check("pwrup_min", {31'd0, (mq[0][40:9] - rel) >= 32'(PWR*T)}, 1);
      check("pwrup_max", {31'd0, (mq[0][40:9] - rel) <= 32'((PWR+3)*T)}, 1);
    end
    check("idle_busy", {31'd0, m_busy}, 0);

    // HELLO frame, with a mid-frame change of message_in and a stray msg_valid.
    mq.delete();
    @(negedge clock);
    m_msg = hello[255:0];
    m_valid = 1;
    @(posedge clock);
    #1;
    check("hs_ready_drop", {31'd0, m_ready}, 0);
    check("hs_busy_rise", {31'd0, m_busy}, 1);
    @(negedge clock);
    m_valid = 0;
    n = 0;
    while (mq.size() < 10 && n < 1000) begin @(negedge clock); n++; end
    check("mid_reach", {31'd0, mq.size() >= 10}, 1);
    m_msg = fa[255:0];
    m_valid = 1;
    ready_leak = 0;
    repeat (20) begin
      @(negedge clock);
      if (m_ready !== 1'b0) ready_leak++;
    end
    m_valid = 0;
    check("busy_ignores_valid", ready_leak, 0);
    wait_ready("hello", 0, 3000);
    obs_q = mq;
    exp_q.delete();
    add_frame(2, 16, hello);
    cmp_seq("hello");
    check("e_width", bad_width, 0);
    check("rs_d_stable", unstable, 0);

    // Second frame only after returning to idle.
    mq.delete();
    @(negedge clock);
    m_msg = fb[255:0];
    m_valid = 1;
    @(negedge clock);
    m_valid = 0;
    wait_ready("frame2", 0, 3000);
    obs_q = mq;
    exp_q.delete();
    add_frame(2, 16, fb);
    cmp_seq("frame2");

    // Asynchronous reset while E is high on a data byte.
    @(negedge clock);
    m_msg = fc[255:0];
    m_valid = 1;
    @(negedge clock);
    m_valid = 0;
    n = 0;
    while (!(m_en === 1'b1 && m_rs === 1'b1) && n < 1000) begin @(negedge clock); n++; end
    check("data_t1_reach", {31'd0, m_en & m_rs}, 1);
    #2 m_rst = 0;
    #1;
    check("arst_en", {31'd0, m_en}, 0);
    check("arst_busy", {31'd0, m_busy}, 1);
    check("arst_ready", {31'd0, m_ready}, 0);
    repeat (2) @(negedge clock);
    mq.delete();
    m_rst = 1;
    rel = cyc;
    wait_ready("reinit", 0, 3000);
    obs_q = mq;
    exp_q.delete();
    add_init(2);
    cmp_seq("reinit");
    check_init_gaps("reinit");
    if (mq.size() > 0)
      check("re_pwrup_min", {31'd0, (mq[0][40:9] - rel) >= 32'(PWR*T)}, 1);

    // 4x20 panel: row bases 80, C0, 94, D4.
    w_rst = 1;
    wait_ready("wide_init", 1, 3000);
    obs_q = wq;
    exp_q.delete();
    add_init(4);
    cmp_seq("wide_init");
    wq.delete();
    @(negedge clock);
    w_msg = fa;
    w_valid = 1;
    @(negedge clock);
    w_valid = 0;
    wait_ready("wide", 1, 4000);
    obs_q = wq;
    exp_q.delete();
    add_frame(4, 20, fa);
    cmp_seq("wide");

    // Auto-refresh: frames back to back, message change lands on the next frame.
    a_msg = fb[255:0];
    a_rst = 1;
    n = 0;
    while (aq.size() < 16 && n < 3000) begin @(negedge clock); n++; end
    check("auto_mid_reach", {31'd0, aq.size() >= 16}, 1);
    a_msg = fc[255:0];
    n = 0;
    while (aq.size() < 6 + 3*34 && n < 5000) begin @(negedge clock); n++; end
    check("auto_end_reach", {31'd0, aq.size() >= 6 + 3*34}, 1);
    obs_q = aq;
    while (obs_q.size() > 6 + 3*34) void'(obs_q.pop_back());
    exp_q.delete();
    add_init(2);
    add_frame(2, 16, fb);
    add_frame(2, 16, fc);
    add_frame(2, 16, fc);
    cmp_seq("auto");
    if (obs_q.size() >= 6 + 3*34) begin
      check("auto_gap1", obs_q[6+34][40:9] - obs_q[6+33][40:9], 32'(3*T));
      check("auto_gap2", obs_q[6+68][40:9] - obs_q[6+67][40:9], 32'(3*T));
    end
    check("rw_low", rw_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_text_ctrl.md
Name: lcd_text_ctrl

Overview:
- Parametrised HD44780-class character-LCD controller in 8-bit write-only mode.
- Runs from the fast system clock and generates its own enable-pulse and command timing from tick counts.
- Supports 1/2/4-row panels of configurable width.
- Accepts whole-screen frames via a valid/ready handshake and writes each row with the correct DDRAM base address.

Parameters:
ROWS, 2, panel rows; legal 1, 2, 4
COLS, 16, characters per row; 8..40 (≤20 when ROWS=4)
TICK_CYCLES, 2000, clock cycles per timing tick (40 us at 50 MHz)
POWERUP_TICKS, 500, ticks waited after reset before the first command
CLEAR_TICKS, 50, extra ticks waited after a clear-display command
AUTO_REFRESH, 0, 1 = recapture message_in on every idle entry without msg_valid

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
message_in  in  ROWS*COLS*8  frame; char k=r*COLS+c at bits [8k+7:8k]
msg_valid  in  1  frame on message_in is valid
msg_ready  out  1  controller idle and able to capture a frame
busy  out  1  init or frame write in progress
lcd_en  out  1  LCD E strobe
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  tied 0 (write only)
lcd_d  out  8  LCD data bus

Behaviour:
- Reset (reset=0, asynchronous): lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_d=0, msg_ready=0, busy=1.
  - Tick counter and frame buffer index clear.
  - FSM enters PWRUP.
  - Reset asserted mid-transfer aborts immediately; after release the full init sequence reruns.
- Tick: a one-cycle strobe every TICK_CYCLES clocks. The divider free-runs from reset release. All FSM progress happens on tick strobes only.
- Byte write primitive (WR), 3 ticks per byte:
  - T0: drive lcd_rs and lcd_d, lcd_en=0.
  - T1: lcd_en=1.
  - T2: lcd_en=0, with rs and d held stable.
  - The next byte may start on the following tick.
  - After command 0x01, the FSM additionally waits CLEAR_TICKS ticks.
- States:
  - PWRUP: wait POWERUP_TICKS ticks, then go to INIT.
  - INIT: write the command sequence 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. 0x38 selects 2-line mode when ROWS≥2; 0x30 is used when ROWS=1. Then go to IDLE.
  - IDLE: busy=0, msg_ready=1.
    - msg_valid && msg_ready on a clock edge captures message_in into the internal frame buffer that same cycle, drops msg_ready and raises busy next cycle, then goes to ADDR with row=0.
    - AUTO_REFRESH=1: IDLE captures on the first clock in IDLE regardless of msg_valid.
  - ADDR: command 0x80 | base[row]. base = 0x00, 0x40, 0x14, 0x54 for rows 0..3. Then go to DATA with col=0.
  - DATA: write frame[row*COLS+col] with rs=1, col++.
    - When col=COLS-1 is written: if row=ROWS-1, go to IDLE; else row++ and go to ADDR.
- Row and column counters are sized with $clog2; there is no wrap beyond COLS-1 or ROWS-1.
- msg_valid while busy is ignored. The producer must hold it until a handshake. The frame captured is the one present at the handshake edge; later changes to message_in do not affect the frame being written.
- lcd_rw is constant 0 at all times. lcd_d and lcd_rs change only at T0 of a byte.

Decomposition:
- Package lcd_pkg holds:
  - command constants: FUNC_8B_2L, FUNC_8B_1L, DISP_ON, CLEAR, ENTRY_INC, SET_DDRAM
  - row base address array
  - FSM state enum: PWRUP, INIT, IDLE, ADDR, DATA
  - WR phase enum: T0, T1, T2, WAIT
- One sub-module, lcd_tick_gen (parameter TICK_CYCLES, outputs the tick strobe), instantiated once.

Test Plan:
(Sim parameters for all scenarios: TICK_CYCLES=4, POWERUP_TICKS=5, CLEAR_TICKS=3, ROWS=2, COLS=16.)
1. Reset release, no stimulus -> no lcd_en rise before 5 ticks (20 clocks); then bytes 38,38,38,0C,01,06 with rs=0; 3 ticks between E-rises, plus 3 extra after 01; then msg_ready=1, busy=0.
2. Handshake with the frame "HELLO WORLD     " / "0123456789ABCDEF" -> msg_ready drops next clock; bus shows cmd 80, 16 data bytes 48 45 4C..., cmd C0, 16 bytes 30..46; then msg_ready=1; exactly 34 E pulses, each exactly 1 tick high.
3. Change message_in and pulse msg_valid mid-frame -> written bytes match the captured frame; second frame accepted only after return to IDLE.
4. ROWS=4, COLS=20 -> row address commands 80, C0, 94, D4, with 20 data bytes after each.
5. Assert reset during the T1 of a data byte -> lcd_en=0, busy=1, msg_ready=0 asynchronously; after release, the PWRUP wait and full INIT sequence recur.
6. AUTO_REFRESH=1, msg_valid held 0 -> frames written back-to-back continuously; a mid-frame message_in change appears only on the next frame.
